// File: rtl/ir_nec_transmitter.sv
// NEC infrared frame transmitter.
// Sends an 8-bit address and an 8-bit command as a standard NEC frame on the IR LED pin:
// a 16-unit leader mark, then an 8-unit space, then 32 data bits LSB-first, then a stop mark.
// Each data bit is a 1-unit mark followed by a 1-unit space (bit 0) or a 3-unit space (bit 1).
// A repeat frame is a 16-unit mark, a 4-unit space and a stop mark.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   start        frame request, sampled only while idle
//   repeat_code  sampled with start; 1 = send a repeat frame, addr/cmd ignored
//   addr, cmd    NEC address and command bytes
//   busy         high while a frame is in progress
//   done         one-cycle pulse as the frame ends
//   irda_txd     IR LED drive; marks carry the carrier (or a constant 1), spaces are 0
module ir_nec_transmitter #(
    parameter int unsigned UNIT_CYCLES  = 28125,
    parameter bit          CARRIER_EN   = 1'b1,
    parameter int unsigned CARRIER_HALF = 658
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       repeat_code,
    input  logic [7:0] addr,
    input  logic [7:0] cmd,
    output logic       busy,
    output logic       done,
    output logic       irda_txd
);

    localparam int unsigned CW = $clog2(16 * UNIT_CYCLES);
    localparam int unsigned HW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

    // Terminal count values (duration - 1) for the unit counter.
    localparam logic [CW-1:0] U1M  = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] U3M  = CW'(3 * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] U4M  = CW'(4 * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] U8M  = CW'(8 * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] U16M = CW'(16 * UNIT_CYCLES - 1);
    localparam logic [HW-1:0] HALF_M = HW'(CARRIER_HALF - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLeadMark,
        StLeadSpace,
        StBitMark,
        StBitSpace,
        StStopMark
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   shift_q, shift_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic          rep_q, rep_d;
    logic [HW-1:0] car_cnt_q, car_cnt_d;
    logic          car_ph_q, car_ph_d;
    logic          done_q, done_d;
    logic          txd_q, txd_d;

    logic [CW-1:0] last_cnt;
    logic          at_end;
    logic          mark_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            rep_q     <= 1'b0;
            car_cnt_q <= '0;
            car_ph_q  <= 1'b0;
            done_q    <= 1'b0;
            txd_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            rep_q     <= rep_d;
            car_cnt_q <= car_cnt_d;
            car_ph_q  <= car_ph_d;
            done_q    <= done_d;
            txd_q     <= txd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        rep_d     = rep_q;
        car_cnt_d = car_cnt_q;
        car_ph_d  = car_ph_q;
        done_d    = 1'b0;
        txd_d     = 1'b0;
        last_cnt  = U1M;

        case (state_q)
            StLeadMark:  last_cnt = U16M;
            StLeadSpace: last_cnt = rep_q ? U4M : U8M;
            StBitSpace:  last_cnt = shift_q[0] ? U3M : U1M;
            default:     last_cnt = U1M;
        endcase
        at_end = (cnt_q == last_cnt);

        if (state_q != StIdle) begin
            cnt_d = at_end ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StLeadMark;
                    shift_d   = {~cmd, cmd, ~addr, addr};
                    rep_d     = repeat_code;
                    bit_cnt_d = '0;
                    cnt_d     = '0;
                end
            end
            StLeadMark: begin
                if (at_end) state_d = StLeadSpace;
            end
            StLeadSpace: begin
                if (at_end) state_d = rep_q ? StStopMark : StBitMark;
            end
            StBitMark: begin
                if (at_end) state_d = StBitSpace;
            end
            StBitSpace: begin
                if (at_end) begin
                    shift_d   = {1'b0, shift_q[31:1]};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    // Bit 31 is the last one; never start a 33rd bit.
                    state_d   = (bit_cnt_q == 6'd31) ? StStopMark : StBitMark;
                end
            end
            StStopMark: begin
                if (at_end) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Output is computed from the next state so the register shows it on the state's first cycle.
        mark_d = (state_d == StLeadMark) || (state_d == StBitMark) || (state_d == StStopMark);
        if (mark_d && (state_d != state_q)) begin
            car_cnt_d = '0;
            car_ph_d  = 1'b1;
        end else if (mark_d) begin
            if (car_cnt_q == HALF_M) begin
                car_cnt_d = '0;
                car_ph_d  = ~car_ph_q;
            end else begin
                car_cnt_d = car_cnt_q + 1'b1;
            end
        end
        txd_d = mark_d && (!CARRIER_EN || car_ph_d);
    end

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign irda_txd = txd_q;

endmodule

// File: doc/ir_nec_transmitter.md
Name: ir_nec_transmitter

Overview:
- Transmit side of the IR link used by the IC tester's IRDA receiver front end.
- Serialises an 8-bit address and an 8-bit command into a standard NEC frame on the board's IRDA_TXD pin: 9 ms leader, 4.5 ms space, 32 data bits sent LSB-first, stop burst.
- Also generates NEC repeat codes.
- Used for loopback self-test of the receiver path and for driving IC numbers into a second tester without a handheld remote.

Parameters:
- UNIT_CYCLES, 28125: clock cycles per 562.5 us NEC unit at 50 MHz. Reduced in simulation.
- CARRIER_EN, 1: 1 = mark periods carry a 38 kHz square carrier; 0 = mark is a constant 1.
- CARRIER_HALF, 658: clock cycles per carrier half-period. 50 MHz / (2 × 658) ≈ 38 kHz.

Ports:
- clk  input  1  system clock, 50 MHz on the board.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request to send a frame; sampled only in IDLE.
- repeat_code  input  1  sampled with start; 1 = send a repeat frame; addr and cmd ignored.
- addr  input  8  NEC address byte.
- cmd  input  8  NEC command byte.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse at end of frame.
- irda_txd  output  1  IR LED drive. Mark = carrier or 1; space = 0.

Behaviour:
- Reset values (asserted asynchronously): state = IDLE, busy = 0, done = 0, irda_txd = 0; all counters and the shift register cleared.
- Frame construction: on the rising edge where state = IDLE and start = 1, latch the 32-bit shift register {~cmd, cmd, ~addr, addr}. Bit 0 (addr[0]) is transmitted first.
- Start to busy: busy rises on the cycle after start is sampled.
- States and durations, where U = UNIT_CYCLES and every state lasts an exact cycle count:
  - IDLE: wait for start.
  - LEAD_MARK: 16U.
  - LEAD_SPACE: 8U for a data frame, 4U for a repeat frame.
  - BIT_MARK: 1U.
  - BIT_SPACE: 1U when the current bit is 0, 3U when it is 1. Then shift right; increment the bit counter.
  - STOP_MARK: 1U.
- Transition sequences:
  - Data frame: LEAD_MARK → LEAD_SPACE → (BIT_MARK → BIT_SPACE) × 32 → STOP_MARK → IDLE.
  - Repeat frame: LEAD_MARK → LEAD_SPACE(4U) → STOP_MARK → IDLE.
- Bit counter: 6 bits. After bit 31's space the next state is STOP_MARK; the counter never wraps into a 33rd bit.
- Output during mark states, CARRIER_EN = 1: carrier starts high on the first cycle of every mark and toggles every CARRIER_HALF cycles. The carrier counter restarts at each mark entry.
- Output during mark states, CARRIER_EN = 0: constant 1.
- Output during space states and IDLE: 0.
- irda_txd is registered. It shows the new state's value on the first cycle of that state.
- Frame end: on leaving STOP_MARK, done = 1 for exactly one cycle; in that same cycle busy = 0 and state = IDLE.
- Back-to-back frames: start may be asserted in the done cycle. It is accepted the following cycle at the earliest, so there is a minimum one-cycle IDLE gap between frames.
- start while busy = 1: ignored, no queuing. addr, cmd and repeat_code changes mid-frame have no effect.
- Reset mid-frame: irda_txd drops to 0 immediately; no done pulse; the frame is abandoned.
- Frame length in units:
  - Data frame: 16 + 8 + 64 + 2·(number of ones in the 32-bit word) + 1. Because the complement bytes are included, this is always 16 + 8 + 64 + 32 + 1 = 121U.
  - Repeat frame: 21U.

Test Plan:
- UNIT_CYCLES = 4, CARRIER_EN = 0, addr = 0x00, cmd = 0xFF, start pulsed → busy high for exactly 484 cycles; irda_txd high 64 cycles then low 32. Then 8 bits as "1 high / 1 low unit" (addr 0), then 16 bits with a 3-unit space, then 8 bits as 0, then a 4-cycle stop mark. done pulses once as busy falls.
- UNIT_CYCLES = 4, addr = 0x1C, cmd = 0xF0 → decoded gap widths reproduce 0x0FF0E31C LSB-first; busy length is 484 cycles.
- repeat_code = 1, start → irda_txd high 64, low 16, high 4 cycles; busy = 84 cycles; done pulses once.
- CARRIER_EN = 1, CARRIER_HALF = 3, UNIT_CYCLES = 12 → each bit mark reads 1,1,1,0,0,0,1,1,1,0,0,0; all spaces stay 0.
- start held high continuously → frames separated by exactly one IDLE cycle. Extra start pulses during busy produce no extra frames.
- rst asserted at cycle 200 of a frame → irda_txd = 0 and busy = 0 asynchronously with no done pulse; a new start after rst release produces a full correct frame.
